// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the hazard stall/flush controller: FSM states, the pipeline-enable
// bundle it drives, and the load-use match helper.
package hazard_stall_unit_pkg;

    typedef enum logic [0:0] {
        HzRun     = 1'b0,
        HzMemWait = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CtrlNormal = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0
    };

    // Whole pipeline up to EX/MEM frozen; MEM/WB takes a NOP so WB does not repeat.
    localparam hz_ctrl_t CtrlMemStall = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
        idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1
    };

    localparam hz_ctrl_t CtrlFlush = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_write: 1'b1,
        idex_bubble: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0
    };

    localparam hz_ctrl_t CtrlLoadUse = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_bubble: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0
    };

    function automatic logic load_use_hit(
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs1,
        input logic       id_use_rs2
    );
        logic hit1;
        logic hit2;
        hit1 = id_use_rs1 && (ex_rd == id_rs1);
        hit2 = id_use_rs2 && (ex_rd == id_rs2);
        return ex_memread && (ex_rd != 5'd0) && (hit1 || hit2);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear, used for stall/flush statistics.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller beside the pipeline registers: load-use bubbles, data-memory wait
// freezes and taken-branch flushes, with a sticky memory timeout and performance counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_memread,
    input  logic             EX_branch_taken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_write,
    output logic             IDEX_bubble,
    output logic             EXMEM_write,
    output logic             MEMWB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned    WaitW    = $clog2(MEM_TIMEOUT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic             pending_flush_q;
    logic             pending_flush_d;
    logic [WaitW-1:0] wait_cnt_q;
    logic [WaitW-1:0] wait_cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    logic     mem_stall;
    logic     load_use;
    logic     flush_now;
    hz_ctrl_t ctrl;

    assign mem_stall = MEM_req && !MEM_ready;
    assign load_use  = load_use_hit(EX_memread, EX_rd, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2);
    assign flush_now = (EX_branch_taken || pending_flush_q) && !mem_stall;

    always_comb begin
        ctrl = CtrlNormal;
        if (rst_n) begin
            if (mem_stall) begin
                ctrl = CtrlMemStall;
            end else if (flush_now) begin
                ctrl = CtrlFlush;
            end else if (load_use) begin
                ctrl = CtrlLoadUse;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        // A branch frozen in EX must still flush once the memory releases the pipeline.
        pending_flush_d = mem_stall && (pending_flush_q || EX_branch_taken);

        unique case (state_q)
            HzRun: begin
                if (mem_stall) begin
                    state_d = HzMemWait;
                end
            end
            HzMemWait: begin
                // Leaving on MEM_ready or on a cancelled request; either way no stall this cycle.
                if (!mem_stall) begin
                    state_d = HzRun;
                end else begin
                    if (wait_cnt_q == WaitLast) begin
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_q == WaitLast) begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end
            end
            default: begin
                state_d = HzRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= HzRun;
            pending_flush_q <= 1'b0;
            wait_cnt_q      <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_q       <= timeout_d;
        end
    end

    assign PC_write     = ctrl.pc_write;
    assign IFID_write   = ctrl.ifid_write;
    assign IFID_flush   = ctrl.ifid_flush;
    assign IDEX_write   = ctrl.idex_write;
    assign IDEX_bubble  = ctrl.idex_bubble;
    assign EXMEM_write  = ctrl.exmem_write;
    assign MEMWB_bubble = ctrl.memwb_bubble;
    assign mem_timeout  = timeout_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (!ctrl.pc_write),
        .cnt  (stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (ctrl.ifid_flush),
        .cnt  (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Vector/scoreboard bench for hazard_stall_unit with a short timeout and narrow counters.
module tb_hazard_stall_unit;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 3;
    localparam int          CntMax = (1 << CW) - 1;

    // {PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_write, MEMWB_bubble}
    localparam logic [6:0] N  = 7'b1101010;
    localparam logic [6:0] MS = 7'b0000001;
    localparam logic [6:0] FL = 7'b1111110;
    localparam logic [6:0] LU = 7'b0001110;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp_ctrl;
        logic       exp_to;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
    logic          ID_use_rs1 = 1'b0, ID_use_rs2 = 1'b0, EX_memread = 1'b0;
    logic          EX_branch_taken = 1'b0, MEM_req = 1'b0, MEM_ready = 1'b0;
    logic          PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble;
    logic          EXMEM_write, MEMWB_bubble, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_pass = 0;
    int n_total = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [6:0] exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_use_rs1     (ID_use_rs1),
        .ID_use_rs2     (ID_use_rs2),
        .EX_rd          (EX_rd),
        .EX_memread     (EX_memread),
        .EX_branch_taken(EX_branch_taken),
        .MEM_req        (MEM_req),
        .MEM_ready      (MEM_ready),
        .PC_write       (PC_write),
        .IFID_write     (IFID_write),
        .IFID_flush     (IFID_flush),
        .IDEX_write     (IDEX_write),
        .IDEX_bubble    (IDEX_bubble),
        .EXMEM_write    (EXMEM_write),
        .MEMWB_bubble   (MEMWB_bubble),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    function automatic vec_t mk(
        input logic       r,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       u1,
        input logic       u2,
        input logic [4:0] rd,
        input logic       mr,
        input logic       br,
        input logic       req,
        input logic       rdy,
        input logic [6:0] c,
        input logic       to
    );
        vec_t v;
        v.rst_n = r;   v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr;     v.br = br;   v.req = req; v.rdy = rdy;
        v.exp_ctrl = c; v.exp_to = to;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then post-edge state.
    task automatic run_vec(input vec_t v, input int idx);
        logic [6:0] got;
        logic [6:0] e;
        @(negedge clk);
        rst_n = v.rst_n; ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_use_rs1 = v.u1; ID_use_rs2 = v.u2;
        EX_rd = v.rd; EX_memread = v.mr; EX_branch_taken = v.br;
        MEM_req = v.req; MEM_ready = v.rdy;
        exp_q.push_back(v.exp_ctrl);
        #1;
        got = {PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_write,
               MEMWB_bubble};
        e = exp_q.pop_front();
        check($sformatf("ctrl#%0d", idx), int'(got), int'(e));
        @(posedge clk);
        #1;
        if (!v.rst_n) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!v.exp_ctrl[6] && exp_stall < CntMax) exp_stall++;
            if (v.exp_ctrl[4] && exp_flush < CntMax) exp_flush++;
        end
        check($sformatf("stall_cnt#%0d", idx), int'(stall_cnt), exp_stall);
        check($sformatf("flush_cnt#%0d", idx), int'(flush_cnt), exp_flush);
        check($sformatf("mem_timeout#%0d", idx), int'(mem_timeout), int'(v.exp_to));
    endtask

    initial begin
        //                 rst rs1 rs2 u1 u2 rd mr br req rdy ctrl to
        tbl.push_back(mk(0, 5, 5, 1, 1, 5, 1, 1, 1, 0, N,  0)); // reset masks all hazards
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N,  0));
        tbl.push_back(mk(1, 3, 5, 1, 1, 5, 1, 0, 0, 0, LU, 0)); // load-use via rs2
        tbl.push_back(mk(1, 3, 5, 1, 1, 0, 0, 0, 0, 0, N,  0)); // bubble now in EX
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, N,  0)); // x0 never hazards
        tbl.push_back(mk(1, 5, 7, 0, 1, 5, 1, 0, 0, 0, N,  0)); // rs1 match but unused
        tbl.push_back(mk(1, 5, 7, 1, 0, 5, 1, 0, 0, 0, LU, 0)); // load-use via rs1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, 0)); // 3-cycle memory wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, N,  0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, FL, 0)); // branch beats load-use
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, MS, 0)); // branch frozen in stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, MS, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, FL, 0)); // single flush on release
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N,  0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, MS, 0)); // branch seen only once
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, FL, 0)); // pending flush applies
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N,  0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, 0)); // request cancelled
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N,  0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // Timeout with a branch pending: sets after the 4th MEM_WAIT cycle, stall holds.
        for (int i = 0; i < 6; i++) begin
            run_vec(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, MS, logic'(i >= 4)), 100 + i);
        end
        // Reset mid-wait clears state, pending flush, wait count and counters.
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, N, 0), 200);
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0), 201);
        for (int i = 0; i < 5; i++) begin
            run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, logic'(i == 4)), 300 + i);
        end
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, N, 1), 400);
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 1), 401);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0), 402);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
